// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multiport register file and its clear sequencer.
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks indices 1..DEPTH-1, one per cycle, with busy high for the whole walk.
// Entry 0 is hardwired to zero, so the walk starts at 1 and takes DEPTH-1 cycles.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = '1;

  clr_state_e        state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] idx_q;

  // clr_req is only looked at in IDLE, so requests during a clear neither restart nor extend it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      idx_q   <= IDX_FIRST;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            idx_q   <= IDX_FIRST;
          end
        end
        CLEAR: begin
          if (idx_q == IDX_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= IDX_FIRST;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_multiport.sv
// 2-read / 2-write register file with entry 0 hardwired to zero and a sequenced clear.
// Define REGFILE_BYPASS_EN to forward same-cycle accepted write data onto the read ports.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic [DATA_W-1:0] rd_val_a, rd_val_b;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_ok, wr0_acc, wr1_acc;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_idx (clr_idx)
  );

  // Writes are dropped, not held, while clearing or on the request cycle itself
  assign wr_ok   = !busy && !clr_req;
  assign wr0_acc = wr_en0 && wr_ok && (wr_addr0 != '0);
  assign wr1_acc = wr_en1 && wr_ok && (wr_addr1 != '0);

  always_comb begin
    mem_d = mem_q;
    if (busy) mem_d[clr_idx] = '0;
    if (wr0_acc) mem_d[wr_addr0] = wr_data0;
    if (wr1_acc) mem_d[wr_addr1] = wr_data1;
    mem_d[0] = '0;
  end

  always_comb begin
    rd_val_a = (rd_addr_a == '0) ? '0 : mem_q[rd_addr_a];
    rd_val_b = (rd_addr_b == '0) ? '0 : mem_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    // Port 1 is checked first so it wins when both write ports hit the read address
    if (wr1_acc && (wr_addr1 == rd_addr_a)) rd_val_a = wr_data1;
    else if (wr0_acc && (wr_addr0 == rd_addr_a)) rd_val_a = wr_data0;
    if (wr1_acc && (wr_addr1 == rd_addr_b)) rd_val_b = wr_data1;
    else if (wr0_acc && (wr_addr0 == rd_addr_b)) rd_val_b = wr_data0;
`endif
  end

  always_comb begin
    rd_data_a_d = rd_en_a ? rd_val_a : rd_data_a_q;
    rd_data_b_d = rd_en_b ? rd_val_b : rd_data_b_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      mem_q       <= mem_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport at DATA_W=8, ADDR_W=3.
module tb_regfile_multiport;

  logic       clk;
  logic       rst_n;
  logic       rd_en_a, rd_en_b;
  logic [2:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       wr_en0, wr_en1;
  logic [2:0] wr_addr0, wr_addr1;
  logic [7:0] wr_data0, wr_data1;
  logic       clr_req;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  regfile_multiport #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_a   (rd_en_a),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_en_b   (rd_en_b),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_en0    (wr_en0),
    .wr_addr0  (wr_addr0),
    .wr_data0  (wr_data0),
    .wr_en1    (wr_en1),
    .wr_addr1  (wr_addr1),
    .wr_data1  (wr_data1),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en_a = 0; rd_en_b = 0; wr_en0 = 0; wr_en1 = 0; clr_req = 0;
  endtask

  task automatic write_one(input int port, input logic [2:0] a, input logic [7:0] d);
    if (port == 0) begin wr_en0 = 1; wr_addr0 = a; wr_data0 = d; end
    else begin wr_en1 = 1; wr_addr1 = a; wr_data1 = d; end
    tick();
    wr_en0 = 0; wr_en1 = 0;
  endtask

  task automatic read_two(input logic [2:0] aa, input logic [2:0] ab);
    rd_en_a = 1; rd_addr_a = aa;
    rd_en_b = 1; rd_addr_b = ab;
    tick();
    rd_en_a = 0; rd_en_b = 0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 8; a++) begin
      read_two(3'(a), 3'(7 - a));
      check($sformatf("%s_a%0d", tag, a), rd_data_a, 0);
      check($sformatf("%s_b%0d", tag, 7 - a), rd_data_b, 0);
    end
  endtask

  task automatic fill_ramp();
    for (int a = 1; a < 8; a++) write_one(a % 2, 3'(a), 8'(a * 16));
  endtask

  // Sample busy once per cycle from the cycle after the request; returns how many samples were high.
  task automatic count_busy(output int cnt, input bit poke);
    int k;
    cnt = 0;
    k = 0;
    while (busy && k < 20) begin
      cnt++;
      if (poke && k == 1) begin
        clr_req = 1;
        rd_en_a = 1; rd_addr_a = 3'd7;
        rd_en_b = 1; rd_addr_b = 3'd1;
      end
      if (poke && k == 6) begin
        wr_en0 = 1; wr_addr0 = 3'd1; wr_data0 = 8'h99;
        wr_en1 = 1; wr_addr1 = 3'd7; wr_data1 = 8'h99;
      end
      tick();
      if (poke && k == 1) begin
        check("clr_live_rd_uncleared", rd_data_a, 8'h70);
        check("clr_live_rd_cleared", rd_data_b, 8'h00);
      end
      idle_inputs();
      k++;
    end
  endtask

  initial begin
    int cnt;
    rst_n = 0;
    rd_addr_a = 0; rd_addr_b = 0;
    wr_addr0 = 0; wr_addr1 = 0; wr_data0 = 0; wr_data1 = 0;
    idle_inputs();
    tick();
    tick();
    check("rst_rd_a", rd_data_a, 0);
    check("rst_rd_b", rd_data_b, 0);
    check("rst_busy", busy, 0);
    rst_n = 1;
    tick();

    read_all_zero("rst_mem");

    // Basic write/read, address-0 immunity and read-data hold
    write_one(0, 3'd3, 8'hA5);
    read_two(3'd3, 3'd0);
    check("wr_rd_a3", rd_data_a, 8'hA5);
    check("wr_rd_b0", rd_data_b, 8'h00);
    rd_addr_a = 3'd0;
    tick();
    check("rd_hold", rd_data_a, 8'hA5);
    wr_en0 = 1; wr_addr0 = 3'd0; wr_data0 = 8'hFF;
    wr_en1 = 1; wr_addr1 = 3'd0; wr_data1 = 8'hFF;
    tick();
    idle_inputs();
    read_two(3'd0, 3'd3);
    check("addr0_zero", rd_data_a, 8'h00);
    check("addr3_kept", rd_data_b, 8'hA5);

    // Dual-port write collision and independent writes
    wr_en0 = 1; wr_addr0 = 3'd5; wr_data0 = 8'h11;
    wr_en1 = 1; wr_addr1 = 3'd5; wr_data1 = 8'h22;
    tick();
    wr_addr0 = 3'd2; wr_data0 = 8'h33;
    wr_addr1 = 3'd6; wr_data1 = 8'h44;
    tick();
    idle_inputs();
    read_two(3'd5, 3'd5);
    check("collide_p1_wins", rd_data_a, 8'h22);
    read_two(3'd2, 3'd6);
    check("dual_wr_a2", rd_data_a, 8'h33);
    check("dual_wr_b6", rd_data_b, 8'h44);

    // Same-cycle write and read of one address
    write_one(0, 3'd4, 8'h4C);
    wr_en0 = 1; wr_addr0 = 3'd4; wr_data0 = 8'h5A;
    rd_en_a = 1; rd_addr_a = 3'd4;
    rd_en_b = 1; rd_addr_b = 3'd0;
    tick();
    idle_inputs();
`ifdef REGFILE_BYPASS_EN
    check("same_cyc_rd", rd_data_a, 8'h5A);
`else
    check("same_cyc_rd", rd_data_a, 8'h4C);
`endif
    check("same_cyc_rd0", rd_data_b, 8'h00);
    wr_en0 = 1; wr_addr0 = 3'd4; wr_data0 = 8'h61;
    wr_en1 = 1; wr_addr1 = 3'd4; wr_data1 = 8'h62;
    rd_en_b = 1; rd_addr_b = 3'd4;
    tick();
    idle_inputs();
`ifdef REGFILE_BYPASS_EN
    check("same_cyc_both", rd_data_b, 8'h62);
`else
    check("same_cyc_both", rd_data_b, 8'h5A);
`endif
    read_two(3'd4, 3'd4);
    check("after_same_cyc", rd_data_a, 8'h62);

    // Full clear with an ignored re-request and dropped writes while busy
    fill_ramp();
    read_two(3'd7, 3'd1);
    check("fill_a7", rd_data_a, 8'h70);
    check("fill_b1", rd_data_b, 8'h10);
    clr_req = 1;
    tick();
    clr_req = 0;
    count_busy(cnt, 1'b1);
    check("clr_busy_cycles", cnt, 7);
    tick();
    check("clr_no_restart", busy, 0);
    read_all_zero("clr_mem");

    // Reset aborts a clear in progress
    fill_ramp();
    read_two(3'd7, 3'd2);
    check("pre_abort_a7", rd_data_a, 8'h70);
    clr_req = 1;
    tick();
    clr_req = 0;
    check("abort_busy1", busy, 1);
    tick();
    tick();
    check("abort_busy3", busy, 1);
    rst_n = 0;
    tick();
    check("abort_busy_low", busy, 0);
    check("abort_rd_a", rd_data_a, 0);
    check("abort_rd_b", rd_data_b, 0);
    rst_n = 1;
    tick();
    check("abort_idle", busy, 0);
    read_all_zero("abort_mem");
    clr_req = 1;
    tick();
    clr_req = 0;
    count_busy(cnt, 1'b0);
    check("reclr_busy_cycles", cnt, 7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
